// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA grid display: default 640x480@60 timing,
// colour type and the swap handshake state encoding.
package vga_pkg;
  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int DEF_COLOR_W = 3;
  typedef logic [DEF_COLOR_W-1:0] color_t;
  localparam color_t WHITE = 3'b111;
  localparam color_t BLACK = 3'b000;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic {SWAP_IDLE, SWAP_PENDING} swap_state_t;
endpackage

// File: rtl/vga_timing_gen.sv
// Stage-0 raster counters and raw sync/active flags, advancing on the pixel enable.
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pix_en,
  output cnt_t h,
  output cnt_t v,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic active,
  output logic vblank_tick
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic h_last, v_last;
  assign h_last = (h == cnt_t'(H_TOTAL - 1));
  assign v_last = (v == cnt_t'(V_TOTAL - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + cnt_t'(1);
      end else begin
        h <= h + cnt_t'(1);
      end
    end
  end

  assign hsync_raw = !((h >= cnt_t'(H_ACTIVE + H_FP)) && (h < cnt_t'(H_ACTIVE + H_FP + H_SYNC)));
  assign vsync_raw = !((v >= cnt_t'(V_ACTIVE + V_FP)) && (v < cnt_t'(V_ACTIVE + V_FP + V_SYNC)));
  assign active    = (h < cnt_t'(H_ACTIVE)) && (v < cnt_t'(V_ACTIVE));
  // Tick on which the counters step onto the first vblank line at h=0.
  assign vblank_tick = pix_en && h_last && (v == cnt_t'(V_ACTIVE - 1));
endmodule

// File: rtl/vga_grid_display.sv
// Double-buffered cell grid scaled onto a VGA raster; buffers exchange only at
// vblank start so the displayed frame never tears.
module vga_grid_display import vga_pkg::*; #(
  parameter int GRID_W    = 10,
  parameter int GRID_H    = 20,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int CELL_PX   = 16,
  parameter int ORIGIN_X  = 240,
  parameter int ORIGIN_Y  = 80,
  parameter int BORDER_PX = 2,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = COLOR_W'(WHITE),
  parameter logic [COLOR_W-1:0] BG_COLOR     = COLOR_W'(BLACK),
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        pix_en,
  input  logic                        wr_en,
  input  logic [$clog2(GRID_W)-1:0]   wr_x,
  input  logic [$clog2(GRID_H)-1:0]   wr_y,
  input  logic [COLOR_W-1:0]          wr_color,
  output logic                        wr_ready,
  input  logic                        swap_req,
  output logic                        swap_done,
  output logic [COLOR_W-1:0]          vga_pixel,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        in_display,
  output logic [9:0]                  count_x,
  output logic [9:0]                  count_y
);
  localparam int XW      = $clog2(GRID_W);
  localparam int YW      = $clog2(GRID_H);
  localparam int DEPTH   = GRID_W * GRID_H;
  localparam int AW      = $clog2(DEPTH);
  localparam int CELL_SH = $clog2(CELL_PX);
  localparam int OW      = CNT_W + 2;
  localparam logic signed [OW-1:0] OX    = OW'(ORIGIN_X);
  localparam logic signed [OW-1:0] OY    = OW'(ORIGIN_Y);
  localparam logic signed [OW-1:0] GPX_W = OW'(GRID_W * CELL_PX);
  localparam logic signed [OW-1:0] GPX_H = OW'(GRID_H * CELL_PX);
  localparam logic signed [OW-1:0] B_LO  = OW'(-BORDER_PX);
  localparam logic signed [OW-1:0] BX_HI = OW'(GRID_W * CELL_PX + BORDER_PX);
  localparam logic signed [OW-1:0] BY_HI = OW'(GRID_H * CELL_PX + BORDER_PX);

  typedef logic [COLOR_W-1:0] pix_t;

  // ---------------- stage 0: raster ----------------
  cnt_t h0, v0;
  logic hs0, vs0, act0, vblank_tick;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clock      (clock),
    .reset_n    (reset_n),
    .pix_en     (pix_en),
    .h          (h0),
    .v          (v0),
    .hsync_raw  (hs0),
    .vsync_raw  (vs0),
    .active     (act0),
    .vblank_tick(vblank_tick)
  );

  logic signed [OW-1:0] dx, dy;
  logic gx_in, gy_in, bx_in, by_in, grid0, border0;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [AW-1:0] addr0;

  always_comb begin
    dx      = $signed({2'b00, h0}) - OX;
    dy      = $signed({2'b00, v0}) - OY;
    gx_in   = !dx[OW-1] && (dx < GPX_W);
    gy_in   = !dy[OW-1] && (dy < GPX_H);
    bx_in   = (dx >= B_LO) && (dx < BX_HI);
    by_in   = (dy >= B_LO) && (dy < BY_HI);
    grid0   = gx_in && gy_in;
    // Border is the frame of the enlarged rectangle; collapses to nothing at width 0.
    border0 = bx_in && by_in && !grid0;
    cx      = dx[CELL_SH +: XW];
    cy      = dy[CELL_SH +: YW];
    addr0   = grid0 ? AW'(int'(cy) * GRID_W + int'(cx)) : '0;
  end

  // ---------------- stage 1: classification registers ----------------
  cnt_t h1, v1;
  logic hs1, vs1, act1, grid1, border1;
  logic [AW-1:0] addr1;

  // ---------------- frame buffers ----------------
  pix_t bank0 [DEPTH];
  pix_t bank1 [DEPTH];
  logic front_sel;
  logic wr_ok;
  logic [AW-1:0] wr_addr;
  pix_t rd_data;

  assign wr_ok   = wr_en && wr_ready && (int'(wr_x) < GRID_W) && (int'(wr_y) < GRID_H);
  assign wr_addr = AW'(int'(wr_y) * GRID_W + int'(wr_x));

  always_ff @(posedge clock) begin
    if (wr_ok && front_sel) bank0[wr_addr] <= wr_color;
  end

  always_ff @(posedge clock) begin
    if (wr_ok && !front_sel) bank1[wr_addr] <= wr_color;
  end

  assign rd_data = front_sel ? bank1[addr1] : bank0[addr1];

  // ---------------- swap handshake ----------------
  swap_state_t state, state_nx;
  logic swap_fire;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= SWAP_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    swap_fire = 1'b0;
    case (state)
      SWAP_IDLE:    if (swap_req) state_nx = SWAP_PENDING;
      SWAP_PENDING: if (vblank_tick) begin
        swap_fire = 1'b1;
        // A request landing on the swap point queues the next frame's exchange.
        state_nx  = swap_req ? SWAP_PENDING : SWAP_IDLE;
      end
      default:      state_nx = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      front_sel <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= swap_fire;
      if (swap_fire) front_sel <= !front_sel;
    end
  end

  assign wr_ready = (state == SWAP_IDLE);

  // ---------------- stages 1 and 2 ----------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      h1         <= '0;
      v1         <= '0;
      hs1        <= 1'b1;
      vs1        <= 1'b1;
      act1       <= 1'b0;
      grid1      <= 1'b0;
      border1    <= 1'b0;
      addr1      <= '0;
      count_x    <= '0;
      count_y    <= '0;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
      in_display <= 1'b0;
      vga_pixel  <= '0;
    end else if (pix_en) begin
      h1         <= h0;
      v1         <= v0;
      hs1        <= hs0;
      vs1        <= vs0;
      act1       <= act0;
      grid1      <= grid0;
      border1    <= border0;
      addr1      <= addr0;
      count_x    <= h1;
      count_y    <= v1;
      hsync_out  <= hs1;
      vsync_out  <= vs1;
      in_display <= act1;
      if (!act1)        vga_pixel <= '0;
      else if (grid1)   vga_pixel <= rd_data;
      else if (border1) vga_pixel <= BORDER_COLOR;
      else              vga_pixel <= BG_COLOR;
    end
  end
endmodule

// File: tb/tb_vga_grid_display.sv
// Scoreboard bench: a raster/buffer model pushes expected outputs per pixel tick and
// pops them two ticks later; handshake outputs are compared every clock.
module tb_vga_grid_display;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int GW = 10, GH = 20, CP = 2, OX = 20, OY = 4, BW = 2;
  localparam logic [2:0] BC = 3'b111;
  localparam logic [2:0] BG = 3'b001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, pix_en, wr_en, swap_req;
  logic [3:0] wr_x;
  logic [4:0] wr_y;
  logic [2:0] wr_color;
  logic       wr_ready, swap_done, hsync_out, vsync_out, in_display;
  logic [2:0] vga_pixel;
  logic [9:0] count_x, count_y;

  vga_grid_display #(
    .GRID_W(GW), .GRID_H(GH), .COLOR_W(3), .CELL_PX(CP), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .BORDER_PX(BW), .BORDER_COLOR(BC), .BG_COLOR(BG),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clock(clk), .reset_n(reset_n), .pix_en(pix_en),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .wr_ready(wr_ready),
    .swap_req(swap_req), .swap_done(swap_done),
    .vga_pixel(vga_pixel), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .in_display(in_display), .count_x(count_x), .count_y(count_y)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] v;
    bit          pix_dc;
    int          x;
    int          y;
  } exp_t;

  exp_t       q[$];
  int         mh, mv, cyc, pe_div;
  bit         m_pend, m_sel;
  bit         known [2];
  logic [2:0] mem [2][GW*GH];

  function automatic logic [63:0] pack_out();
    return {38'd0, hsync_out, vsync_out, in_display, count_x, count_y, vga_pixel};
  endfunction

  function automatic exp_t expect_at(int x, int y);
    exp_t e;
    bit de, hs, vs, grid, bord;
    logic [2:0] p;
    int gx, gy;
    de = (x < HA) && (y < VA);
    hs = !((x >= HA + HF) && (x < HA + HF + HS));
    vs = !((y >= VA + VF) && (y < VA + VF + VS));
    gx = x - OX;
    gy = y - OY;
    grid = (gx >= 0) && (gx < GW*CP) && (gy >= 0) && (gy < GH*CP);
    bord = !grid && (gx >= -BW) && (gx < GW*CP + BW) && (gy >= -BW) && (gy < GH*CP + BW);
    e.pix_dc = 1'b0;
    if (!de) p = 3'b000;
    else if (grid) begin
      p = mem[m_sel][(gy / CP) * GW + gx / CP];
      e.pix_dc = !known[m_sel];
    end
    else if (bord) p = BC;
    else p = BG;
    e.v = {38'd0, hs, vs, de, 10'(x), 10'(y), p};
    e.x = x;
    e.y = y;
    return e;
  endfunction

  // One clock: model the edge, let the DUT take it, then compare.
  task automatic step();
    exp_t e;
    logic [63:0] act;
    bit pe, sp, sd_exp;
    pix_en = ((cyc % pe_div) == 0);
    cyc++;
    pe = pix_en;
    if (!reset_n) begin
      mh = 0; mv = 0; m_pend = 0; m_sel = 0;
      q.delete();
      @(posedge clk); #1;
      chk("reset_outputs", pack_out(), {38'd0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 3'd0});
      chk("reset_wr_ready", wr_ready, 1'b1);
      chk("reset_swap_done", swap_done, 1'b0);
      return;
    end
    sp = pe && (mh == HT - 1) && (mv == VA - 1);
    if (pe) begin
      q.push_back(expect_at(mh, mv));
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end
    if (wr_en && !m_pend && (wr_x < GW) && (wr_y < GH))
      mem[m_sel ? 0 : 1][int'(wr_y) * GW + int'(wr_x)] = wr_color;
    sd_exp = 1'b0;
    if (m_pend) begin
      if (sp) begin
        m_sel  = !m_sel;
        sd_exp = 1'b1;
        m_pend = swap_req;
      end
    end else if (swap_req) m_pend = 1'b1;
    @(posedge clk); #1;
    if (pe && q.size() == 2) begin
      e = q.pop_front();
      act = pack_out();
      if (e.pix_dc) begin
        act[2:0] = 3'b000;
        e.v[2:0] = 3'b000;
      end
      chk($sformatf("pixel(%0d,%0d)", e.x, e.y), act, e.v);
    end
    chk("wr_ready", wr_ready, !m_pend);
    chk("swap_done", swap_done, sd_exp);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input int x, input int y, input logic [2:0] c);
    wr_en = 1'b1; wr_x = 4'(x); wr_y = 5'(y); wr_color = c;
    step();
    wr_en = 1'b0;
  endtask

  task automatic fill_back(input int seed);
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++)
        wr(x, y, 3'((x * 3 + y + seed) % 8));
    known[m_sel ? 0 : 1] = 1'b1;
  endtask

  task automatic request_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic wait_swap(input int bound);
    int k = 0;
    while (!swap_done && k < bound) begin
      step();
      k++;
    end
    chk("swap_seen", swap_done, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0; pix_en = 1'b1; wr_en = 1'b0; swap_req = 1'b0;
    wr_x = '0; wr_y = '0; wr_color = '0;
    cyc = 0; pe_div = 1;
    known[0] = 1'b0; known[1] = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < GW*GH; i++) mem[b][i] = 3'b000;

    run(3);
    reset_n = 1'b1;

    // Fill back bank, mark corners, try an out-of-range write, then swap.
    fill_back(0);
    wr(0, 0, 3'b101);
    wr(9, 19, 3'b010);
    wr(12, 3, 3'b111);
    request_swap();
    wr(0, 0, 3'b000);
    wr(5, 5, 3'b011);
    wait_swap(2 * HT * VT);
    run(HT * VT);

    // Second bank, second swap: both banks now have known contents.
    fill_back(5);
    request_swap();
    wait_swap(2 * HT * VT);
    run(HT * 4);

    // Pixel enable every 4th clock; writes and handshake still run every clock.
    pe_div = 4;
    fill_back(9);
    request_swap();
    wait_swap(2 * 4 * HT * VT);
    run(4 * HT * VA);

    // Reset in the middle of a line.
    pe_div = 1;
    begin
      int k = 0;
      while (!(mh == 30 && mv > 0) && k < 2 * HT * VT) begin
        step();
        k++;
      end
      chk("midline_reached", 10'(mh), 10'd30);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    run(HT * 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
